multicycle_ctrl: RTL

//  Multicycle control FSM for the MIPS datapath: sequences fetch/decode/exec/mem/writeback.

---
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Signal bundle between the multicycle control FSM and the MIPS datapath/memory.
// Memory handshake: Mem_Req stays high until Mem_Ack is seen high at a rising Clk edge,
// and that edge completes the access. Mem_Ack may be a pulse or a level and is ignored while Mem_Req=0.
interface multicycle_ctrl_if;
  logic [5:0] Instr_Op;
  logic [3:0] Func;
  logic       Zero;
  logic       Mem_Ack;
  logic       PC_LdEn;
  logic       PC_sel;
  logic       IR_LdEn;
  logic       RF_WrEn;
  logic       RF_B_sel;
  logic       RF_WrData_sel;
  logic       ALU_Bin_sel;
  logic [3:0] ALU_func;
  logic [1:0] ImmSel;
  logic       Mem_Req;
  logic       Mem_WrEn;
  logic       ByteOp;
  logic [2:0] State;
  logic       Trap;

  modport master (
    input  Instr_Op, Func, Zero, Mem_Ack,
    output PC_LdEn, PC_sel, IR_LdEn, RF_WrEn, RF_B_sel, RF_WrData_sel, ALU_Bin_sel,
           ALU_func, ImmSel, Mem_Req, Mem_WrEn, ByteOp, State, Trap
  );

  modport slave (
    output Instr_Op, Func, Zero, Mem_Ack,
    input  PC_LdEn, PC_sel, IR_LdEn, RF_WrEn, RF_B_sel, RF_WrData_sel, ALU_Bin_sel,
           ALU_func, ImmSel, Mem_Req, Mem_WrEn, ByteOp, State, Trap
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB), with a sticky TRAP
// state entered on an illegal opcode or a memory handshake that outlasts TIMEOUT cycles.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic             Clk,
  input logic             Reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU, CLS_BRANCH, CLS_LOAD, CLS_STORE
  } op_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_SB    = 6'b000111;

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic [5:0] op_q;
  logic       timeout_hit;

  // Decoded datapath controls for the instruction held in op_q
  op_class_t  d_cls;
  logic [1:0] d_imm;
  logic [3:0] d_func;
  logic       d_bin, d_bsel, d_wdsel, d_byte, d_pcsel;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_B,
      OP_BEQ, OP_BNE, OP_LW, OP_LB, OP_SW, OP_SB: op_legal = 1'b1;
      default:                                    op_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    d_cls   = CLS_ALU;
    d_imm   = 2'b00;
    d_func  = 4'b0000;
    d_bin   = 1'b0;
    d_bsel  = 1'b0;
    d_wdsel = 1'b0;
    d_byte  = 1'b0;
    d_pcsel = 1'b0;
    case (op_q)
      OP_RTYPE: d_func = bus.Func;
      OP_ADDI:  d_bin = 1'b1;
      OP_ANDI:  begin d_imm = 2'b01; d_func = 4'b0010; d_bin = 1'b1; end
      OP_ORI:   begin d_imm = 2'b01; d_func = 4'b0011; d_bin = 1'b1; end
      OP_LUI:   begin d_imm = 2'b10; d_bin = 1'b1; end
      OP_B:     begin d_cls = CLS_BRANCH; d_imm = 2'b11; d_pcsel = 1'b1; end
      OP_BEQ:   begin
        d_cls = CLS_BRANCH; d_imm = 2'b11; d_func = 4'b0001; d_bsel = 1'b1;
        d_pcsel = bus.Zero;
      end
      OP_BNE:   begin
        d_cls = CLS_BRANCH; d_imm = 2'b11; d_func = 4'b0001; d_bsel = 1'b1;
        d_pcsel = ~bus.Zero;
      end
      OP_LW:    begin d_cls = CLS_LOAD; d_bin = 1'b1; d_wdsel = 1'b1; end
      OP_LB:    begin d_cls = CLS_LOAD; d_bin = 1'b1; d_wdsel = 1'b1; d_byte = 1'b1; end
      OP_SW:    begin d_cls = CLS_STORE; d_bin = 1'b1; d_bsel = 1'b1; end
      OP_SB:    begin d_cls = CLS_STORE; d_bin = 1'b1; d_bsel = 1'b1; d_byte = 1'b1; end
      default:  ;
    endcase
  end

  // The cycle in which the counter would reach TIMEOUT traps, unless Mem_Ack arrives in it
  assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1)) && !bus.Mem_Ack;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
      op_q     <= 6'd0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= 8'd0;
      else if ((state == S_FETCH || state == S_MEM) && !bus.Mem_Ack)
        wait_cnt <= wait_cnt + 8'd1;
      if (state == S_DECODE)
        op_q <= bus.Instr_Op;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (bus.Mem_Ack)   state_next = S_DECODE;
        else if (timeout_hit) state_next = S_TRAP;
      end
      S_DECODE: state_next = op_legal(bus.Instr_Op) ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (d_cls)
          CLS_ALU:    state_next = S_WB;
          CLS_BRANCH: state_next = S_FETCH;
          default:    state_next = S_MEM;
        endcase
      end
      S_MEM: begin
        if (bus.Mem_Ack)      state_next = (d_cls == CLS_STORE) ? S_FETCH : S_WB;
        else if (timeout_hit) state_next = S_TRAP;
      end
      S_WB:    state_next = S_FETCH;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_TRAP;
    endcase
  end

  // Reset forces every output low at once, even while the access is still in flight
  always_comb begin
    bus.PC_LdEn       = 1'b0;
    bus.PC_sel        = 1'b0;
    bus.IR_LdEn       = 1'b0;
    bus.RF_WrEn       = 1'b0;
    bus.RF_B_sel      = 1'b0;
    bus.RF_WrData_sel = 1'b0;
    bus.ALU_Bin_sel   = 1'b0;
    bus.ALU_func      = 4'b0000;
    bus.ImmSel        = 2'b00;
    bus.Mem_Req       = 1'b0;
    bus.Mem_WrEn      = 1'b0;
    bus.ByteOp        = 1'b0;
    bus.Trap          = 1'b0;
    bus.State         = state;
    if (!Reset) begin
      if (state == S_EXEC || state == S_MEM || state == S_WB) begin
        bus.RF_B_sel      = d_bsel;
        bus.RF_WrData_sel = d_wdsel;
        bus.ALU_Bin_sel   = d_bin;
        bus.ALU_func      = d_func;
        bus.ImmSel        = d_imm;
        bus.ByteOp        = d_byte;
      end
      case (state)
        S_FETCH: begin
          bus.Mem_Req = 1'b1;
          bus.IR_LdEn = bus.Mem_Ack;
        end
        S_EXEC: begin
          if (d_cls == CLS_BRANCH) begin
            bus.PC_LdEn = 1'b1;
            bus.PC_sel  = d_pcsel;
          end
        end
        S_MEM: begin
          bus.Mem_Req  = 1'b1;
          bus.Mem_WrEn = (d_cls == CLS_STORE);
          bus.PC_LdEn  = bus.Mem_Ack && (d_cls == CLS_STORE);
        end
        S_WB: begin
          bus.RF_WrEn = 1'b1;
          bus.PC_LdEn = 1'b1;
        end
        S_TRAP:  bus.Trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
